pci_initiator: RTL

PCI bus initiator (master) that drives the PCI target block through the shared Frame/AD/CBE/Irdy bus and samples its Devsel/Trdy replies. It accepts one burst request at a time from a local requester (memory read, command 6, or memory write, command 7), runs the address phase and up to MAX_BURST data phases, and returns read data and completion status. AD is split into AdOut/AdOe plus AdIn; the tristate sits at the top level.

---
 rtl/pci_pkg.sv | 36 +++
 rtl/pci_initiator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pci_pkg
// Description : Shared PCI initiator definitions: bus commands, active
//               signal levels, initiator state encoding and burst-length
//               clamping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pci_pkg;

  // PCI bus commands driven on CBE during the address phase
  localparam logic [3:0] CMD_MEM_READ  = 4'h6;
  localparam logic [3:0] CMD_MEM_WRITE = 4'h7;

  // Frame/Irdy/Devsel/Trdy are active-low on the bus
  localparam logic ACTIVE_LVL   = 1'b0;
  localparam logic INACTIVE_LVL = 1'b1;

  // Initiator bus-cycle states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    TURN = 2'd3
  } state_t;

  // Requested length 0 means one phase; anything above the burst cap is cut
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pci_initiator.sv
`default_nettype none
// ============================================================================
// Module      : pci_initiator
// Description : PCI bus master. Accepts one memory read/write burst request,
//               runs the address phase and up to MAX_BURST data phases,
//               returns read data and completion / master-abort status.
//               AD is split into AdOut/AdOe/AdIn; tristate lives above.
// Revision    : 1.0 - initial release
// ============================================================================
module pci_initiator
  import pci_pkg::*;
#(
  parameter int MAX_BURST      = 4,
  parameter int DEVSEL_TIMEOUT = 4,
  parameter int LEN_W          = 3
) (
  input  logic             Clock,
  input  logic             RST,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic             ReqWrite,
  input  logic [31:0]      ReqAddr,
  input  logic [LEN_W-1:0] ReqLen,
  input  logic [3:0]       ReqBE,
  input  logic [31:0]      WrData,
  output logic             WrPop,
  output logic [31:0]      RdData,
  output logic             RdValid,
  output logic             Done,
  output logic             Abort,
  output logic             Frame,
  output logic             Irdy,
  output logic [3:0]       CBE,
  output logic [31:0]      AdOut,
  output logic             AdOe,
  input  logic [31:0]      AdIn,
  input  logic             Devsel,
  input  logic             Trdy
);

  localparam int                TMO_W      = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  c_tmo_last = TMO_W'(DEVSEL_TIMEOUT - 1);
  localparam logic [LEN_W-1:0]  c_len_one  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  c_len_two  = LEN_W'(2);

  state_t             r_state;
  logic               r_write;
  logic [3:0]         r_be;
  logic [LEN_W-1:0]   r_remain;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_claimed;
  logic               r_frame;
  logic               r_irdy;
  logic [3:0]         r_cbe;
  logic [31:0]        r_adout;
  logic               r_adoe;
  logic [31:0]        r_rddata;
  logic               r_rdvalid;
  logic               r_wrpop;
  logic               r_done;
  logic               r_abort;

  logic               w_req_ready;
  logic               w_xfer;
  logic               w_last;
  logic               w_tmo_hit;

  // Requests are only taken in IDLE and never while reset is applied
  assign w_req_ready = (r_state == IDLE) && RST;

  // A data phase completes only when all three handshake lines are asserted
  assign w_xfer = (r_state == DATA) && (r_irdy == ACTIVE_LVL) &&
                  (Trdy == ACTIVE_LVL) && (Devsel == ACTIVE_LVL);

  assign w_last = (r_remain == c_len_one);

  // Abort once the last unclaimed cycle before the timeout still sees no Devsel
  assign w_tmo_hit = (r_state == DATA) && !r_claimed &&
                     (Devsel == INACTIVE_LVL) && (r_tmo == c_tmo_last);

  assign ReqReady = w_req_ready;
  assign WrPop    = r_wrpop;
  assign RdData   = r_rddata;
  assign RdValid  = r_rdvalid;
  assign Done     = r_done;
  assign Abort    = r_abort;
  assign Frame    = r_frame;
  assign Irdy     = r_irdy;
  assign CBE      = r_cbe;
  assign AdOe     = r_adoe;
  // Write data passes straight through so the requester's current word is on AD
  assign AdOut    = ((r_state == DATA) && r_write) ? WrData : r_adout;

  // Bus-cycle sequencer with registered bus outputs and status pulses
  always_ff @(posedge Clock) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      r_be      <= 4'h0;
      r_remain  <= '0;
      r_tmo     <= '0;
      r_claimed <= 1'b0;
      r_frame   <= INACTIVE_LVL;
      r_irdy    <= INACTIVE_LVL;
      r_cbe     <= 4'h0;
      r_adout   <= 32'h0;
      r_adoe    <= 1'b0;
      r_rddata  <= 32'h0;
      r_rdvalid <= 1'b0;
      r_wrpop   <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_rdvalid <= 1'b0;
      r_wrpop   <= 1'b0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (ReqValid && w_req_ready) begin
            r_state   <= ADDR;
            r_write   <= ReqWrite;
            r_be      <= ReqBE;
            r_remain  <= LEN_W'(clamp_len(32'(ReqLen), MAX_BURST));
            r_tmo     <= '0;
            r_claimed <= 1'b0;
            r_frame   <= ACTIVE_LVL;
            r_irdy    <= INACTIVE_LVL;
            r_cbe     <= ReqWrite ? CMD_MEM_WRITE : CMD_MEM_READ;
            r_adout   <= ReqAddr;
            r_adoe    <= 1'b1;
          end
        end

        ADDR: begin
          r_state <= DATA;
          r_frame <= w_last ? INACTIVE_LVL : ACTIVE_LVL;
          r_irdy  <= ACTIVE_LVL;
          r_cbe   <= r_be;
          r_adout <= 32'h0;
          // Reads release AD here so the target owns it from the first data phase
          r_adoe  <= r_write;
        end

        DATA: begin
          if (Devsel == ACTIVE_LVL) begin
            r_claimed <= 1'b1;
          end else if (!r_claimed) begin
            r_tmo <= r_tmo + TMO_W'(1);
          end

          if (w_xfer) begin
            r_remain <= r_remain - c_len_one;
            if (r_write) begin
              r_wrpop <= 1'b1;
            end else begin
              r_rddata  <= AdIn;
              r_rdvalid <= 1'b1;
            end
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= TURN;
              r_frame <= INACTIVE_LVL;
              r_irdy  <= INACTIVE_LVL;
              r_adoe  <= 1'b0;
              r_cbe   <= 4'h0;
            end else begin
              // Frame is released for the final data phase
              r_frame <= (r_remain == c_len_two) ? INACTIVE_LVL : ACTIVE_LVL;
            end
          end else if (w_tmo_hit) begin
            r_abort <= 1'b1;
            r_state <= TURN;
            r_frame <= INACTIVE_LVL;
            r_irdy  <= INACTIVE_LVL;
            r_adoe  <= 1'b0;
            r_cbe   <= 4'h0;
          end
        end

        TURN: begin
          r_state <= IDLE;
          r_frame <= INACTIVE_LVL;
          r_irdy  <= INACTIVE_LVL;
          r_adoe  <= 1'b0;
          r_cbe   <= 4'h0;
          r_adout <= 32'h0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
